// File: rtl/video_timing_if.sv
// Raster timing bundle between the pixel-domain timing generator and its
// consumers (serialiser, draw-side line fetcher).
//   sx, sy          current column / line
//   hsync, vsync, de  pipeline-aligned sync and data enable
//   line_start      high while sx==0
//   frame_start     high while sx==0 && sy==0
//   line_req        fetch request for line line_req_y
//   line_req_y      requested line, stable while line_req is high
//   line_ack        draw side accepts the current request
//   underrun        one-cycle pulse when a request missed its deadline
//   underrun_cnt    saturating count of missed requests
interface video_timing_if #(
  parameter int unsigned CW = 10
);
  logic [CW-1:0] sx;
  logic [CW-1:0] sy;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic          line_start;
  logic          frame_start;
  logic          line_req;
  logic [CW-1:0] line_req_y;
  logic          line_ack;
  logic          underrun;
  logic [7:0]    underrun_cnt;

  modport master (
    output sx, sy, hsync, vsync, de, line_start, frame_start,
           line_req, line_req_y, underrun, underrun_cnt,
    input  line_ack
  );

  modport slave (
    input  sx, sy, hsync, vsync, de, line_start, frame_start,
           line_req, line_req_y, underrun, underrun_cnt,
    output line_ack
  );
endinterface

// File: rtl/video_timing.sv
// Raster timing generator for the pixel domain. Free-running sx/sy counters
// drive hsync/vsync/de (delayed PIPE cycles to match the pixel pipeline) and
// a per-line fetch handshake that asks the draw side for the next active line
// and counts missed deadlines.
//   clk_pix   pixel clock
//   rst_pix   asynchronous active-high reset
//   vt        timing bundle (master side), see video_timing_if
module video_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned PIPE     = 2,
  parameter int unsigned CW       = 10
) (
  input  logic           clk_pix,
  input  logic           rst_pix,
  video_timing_if.master vt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  // Elaboration-time parameter sanity
  if (PIPE < 1 || PIPE > 8) begin : g_bad_pipe
    $error("video_timing: PIPE must be 1..8");
  end
  if (CW > 31 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
    $error("video_timing: CW too small for H_TOTAL/V_TOTAL");
  end

  logic [CW-1:0]   sx_q, sy_q, sx_d, sy_d, y_next;
  logic            line_start_q, frame_start_q;
  logic            hsync_raw, vsync_raw, de_raw;
  logic [PIPE-1:0] hs_pipe, vs_pipe, de_pipe;
  logic [0:0]      state_q, state_d;
  logic            line_req_q, line_req_d;
  logic [CW-1:0]   req_y_q, req_y_d;
  logic            underrun_q, underrun_d;
  logic [7:0]      cnt_q, cnt_d;

  // Next raster position
  always_comb begin
    sx_d = sx_q + CW'(1);
    sy_d = sy_q;
    if (sx_q == CW'(H_TOTAL - 1)) begin
      sx_d = '0;
      sy_d = (sy_q == CW'(V_TOTAL - 1)) ? '0 : sy_q + CW'(1);
    end
  end

  // Undelayed sync/enable decode of the current position
  always_comb begin
    hsync_raw = (sx_q >= CW'(HS_BEG) && sx_q < CW'(HS_END)) ? H_POL : ~H_POL;
    vsync_raw = (sy_q >= CW'(VS_BEG) && sy_q < CW'(VS_END)) ? V_POL : ~V_POL;
    de_raw    = (sx_q < CW'(H_ACTIVE)) && (sy_q < CW'(V_ACTIVE));
  end

  // Fetch FSM: request is armed one cycle early so line_req is visible at sx==H_ACTIVE
  always_comb begin
    state_d    = state_q;
    line_req_d = line_req_q;
    req_y_d    = req_y_q;
    underrun_d = 1'b0;
    cnt_d      = cnt_q;
    y_next     = (sy_q == CW'(V_TOTAL - 1)) ? '0 : sy_q + CW'(1);
    case (state_q)
      IDLE: begin
        if (sx_q == CW'(H_ACTIVE - 1) && y_next < CW'(V_ACTIVE)) begin
          state_d    = REQ;
          line_req_d = 1'b1;
          req_y_d    = y_next;
        end
      end
      REQ: begin
        // Ack on the deadline edge still counts as accepted
        if (vt.line_ack) begin
          state_d    = IDLE;
          line_req_d = 1'b0;
        end else if (sx_q == CW'(H_TOTAL - 1)) begin
          state_d    = IDLE;
          line_req_d = 1'b0;
          underrun_d = 1'b1;
          cnt_d      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        line_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      sx_q          <= '0;
      sy_q          <= '0;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
      hs_pipe       <= {PIPE{~H_POL}};
      vs_pipe       <= {PIPE{~V_POL}};
      de_pipe       <= '0;
      state_q       <= IDLE;
      line_req_q    <= 1'b0;
      req_y_q       <= '0;
      underrun_q    <= 1'b0;
      cnt_q         <= 8'd0;
    end else begin
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      line_start_q  <= (sx_d == '0);
      frame_start_q <= (sx_d == '0) && (sy_d == '0);
      // Oldest stage sits in the MSB and drives the outputs
      hs_pipe       <= PIPE'({hs_pipe, hsync_raw});
      vs_pipe       <= PIPE'({vs_pipe, vsync_raw});
      de_pipe       <= PIPE'({de_pipe, de_raw});
      state_q       <= state_d;
      line_req_q    <= line_req_d;
      req_y_q       <= req_y_d;
      underrun_q    <= underrun_d;
      cnt_q         <= cnt_d;
    end
  end

  assign vt.sx           = sx_q;
  assign vt.sy           = sy_q;
  assign vt.hsync        = hs_pipe[PIPE-1];
  assign vt.vsync        = vs_pipe[PIPE-1];
  assign vt.de           = de_pipe[PIPE-1];
  assign vt.line_start   = line_start_q;
  assign vt.frame_start  = frame_start_q;
  assign vt.line_req     = line_req_q;
  assign vt.line_req_y   = req_y_q;
  assign vt.underrun     = underrun_q;
  assign vt.underrun_cnt = cnt_q;

endmodule

// File: tb/tb_video_timing.sv
// Scoreboarded bench for video_timing on a 16x8 raster (8/2/3/3, 4/1/1/2, PIPE 2).
module tb_video_timing;

  localparam int unsigned CW = 10;
  localparam int HT = 16;
  localparam int VT = 8;
  localparam int HA = 8;
  localparam int VA = 4;
  localparam int HS_B = 10;
  localparam int HS_E = 13;
  localparam int VS_B = 5;
  localparam int VS_E = 6;
  localparam int DLY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_timing_if #(.CW(CW)) vif ();

  video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b0), .PIPE(2), .CW(CW)
  ) dut (
    .clk_pix(clk),
    .rst_pix(rst),
    .vt(vif)
  );

  typedef struct {
    int sx; int sy; int hsync; int vsync; int de; int ls; int fs;
    int req; int req_y; int ur; int cnt;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int mode = 0;
  bit running = 1'b0;

  // Reference model state: cycles since reset release plus pending request
  int n = 0;
  bit pend = 1'b0;
  int pend_y = 0;
  int cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  function automatic snap_t expect_at(input int c);
    snap_t s;
    int m, mx, my;
    s.sx = c % HT;
    s.sy = (c / HT) % VT;
    s.ls = (s.sx == 0) ? 1 : 0;
    s.fs = (s.sx == 0 && s.sy == 0) ? 1 : 0;
    if (c < DLY) begin
      s.hsync = 1; s.vsync = 1; s.de = 0;
    end else begin
      m  = c - DLY;
      mx = m % HT;
      my = (m / HT) % VT;
      s.hsync = (mx >= HS_B && mx < HS_E) ? 0 : 1;
      s.vsync = (my >= VS_B && my < VS_E) ? 0 : 1;
      s.de    = (mx < HA && my < VA) ? 1 : 0;
    end
    s.req   = pend ? 1 : 0;
    s.req_y = pend_y;
    s.ur    = 0;
    s.cnt   = cnt;
    return s;
  endfunction

  task automatic model_reset();
    n = 0; pend = 1'b0; pend_y = 0; cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sx"},    32'(vif.sx), 0);
    check({tag, "_sy"},    32'(vif.sy), 0);
    check({tag, "_hsync"}, 32'(vif.hsync), 1);
    check({tag, "_vsync"}, 32'(vif.vsync), 1);
    check({tag, "_de"},    32'(vif.de), 0);
    check({tag, "_ls"},    32'(vif.line_start), 1);
    check({tag, "_fs"},    32'(vif.frame_start), 1);
    check({tag, "_req"},   32'(vif.line_req), 0);
    check({tag, "_req_y"}, 32'(vif.line_req_y), 0);
    check({tag, "_ur"},    32'(vif.underrun), 0);
    check({tag, "_cnt"},   32'(vif.underrun_cnt), 0);
  endtask

  // Model: advance one pixel per edge using the ack that was present on that edge
  always @(posedge clk) begin
    if (running) begin
      snap_t s;
      bit ur;
      ur = 1'b0;
      if (pend) begin
        if (vif.line_ack === 1'b1) begin
          pend = 1'b0;
        end else if (n % HT == HT - 1) begin
          pend = 1'b0;
          ur = 1'b1;
          if (cnt < 255) cnt++;
        end
      end
      n++;
      if (n % HT == HA && !pend) begin
        int yn;
        yn = ((n / HT) % VT + 1) % VT;
        if (yn < VA) begin
          pend = 1'b1;
          pend_y = yn;
        end
      end
      s = expect_at(n);
      s.ur = ur ? 1 : 0;
      exp_q.push_back(s);
    end
  end

  // Monitor: compare every presented cycle against the queued expectation
  always @(posedge clk) begin
    if (running) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty at t=%0t: actual=0 entries required=1", $time);
      end else begin
        snap_t e;
        e = exp_q.pop_front();
        check("sx",           32'(vif.sx), 32'(e.sx));
        check("sy",           32'(vif.sy), 32'(e.sy));
        check("hsync",        32'(vif.hsync), 32'(e.hsync));
        check("vsync",        32'(vif.vsync), 32'(e.vsync));
        check("de",           32'(vif.de), 32'(e.de));
        check("line_start",   32'(vif.line_start), 32'(e.ls));
        check("frame_start",  32'(vif.frame_start), 32'(e.fs));
        check("line_req",     32'(vif.line_req), 32'(e.req));
        check("line_req_y",   32'(vif.line_req_y), 32'(e.req_y));
        check("underrun",     32'(vif.underrun), 32'(e.ur));
        check("underrun_cnt", 32'(vif.underrun_cnt), 32'(e.cnt));
      end
    end
  end

  // Ack driver, changes away from the sampling edge
  always @(negedge clk) begin
    if (!running) begin
      vif.line_ack = 1'b0;
    end else begin
      case (mode)
        1: vif.line_ack = 1'b0;
        2: vif.line_ack = (n % HT == HT - 1) || (!pend && $urandom_range(0, 3) == 0);
        3: vif.line_ack = pend && (n % HT == HA + 3);
        default: vif.line_ack = pend ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  task automatic run(input int m, input int cycles);
    mode = m;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    vif.line_ack = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    running = 1'b1;

    run(3, 2 * HT * VT);
    run(0, 4 * HT * VT);
    run(2, 2 * HT * VT);
    run(1, 66 * HT * VT);
    run(0, HT * VT);

    // Async reset mid-line while a request is outstanding
    mode = 1;
    begin
      int i;
      for (i = 0; i < 4 * HT * VT && !((n % (HT * VT)) == 2 * HT + 10 && pend); i++)
        @(negedge clk);
      if (i >= 4 * HT * VT) begin
        checks++;
        failures++;
        $display("FAIL reach_pending_point: actual=timeout required=sy2_sx10_pending");
      end
    end
    running = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    running = 1'b1;
    run(0, 2 * HT * VT);

    running = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
